universal_shift_register: RTL and testbench
===========================================

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 8, SHALL set the register width in bits; legal range is 2..32.
REQ-003 Parameter RESET_VALUE, default 0 (WIDTH bits), SHALL set the value loaded into q by reset.
REQ-004 Parameter ROTATE, default 0, SHALL select shift behaviour: 0 means shifts take serial inputs, 1 means shifts rotate and ignore serial inputs.
REQ-005 clk  input  1  SHALL be the clock; all state changes on its rising edge.
REQ-006 reset  input  1  SHALL be the synchronous active-high reset.
REQ-007 e  input  1  SHALL be the enable; when 0 the register holds regardless of mode.
REQ-008 mode  input  2  SHALL select the operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-009 d  input  WIDTH  SHALL be the parallel load data.
REQ-010 sin_r  input  1  SHALL be the serial input entering at the MSB on a right shift.
REQ-011 sin_l  input  1  SHALL be the serial input entering at the LSB on a left shift.
REQ-012 q  output  WIDTH  SHALL be the registered state.
REQ-013 sout_r  output  1  SHALL equal q[0] (combinational from q).
REQ-014 sout_l  output  1  SHALL equal q[WIDTH-1] (combinational from q).
REQ-015 zero  output  1  SHALL be 1 exactly when q is all zeros (combinational from q).
REQ-016 changed  output  1  SHALL be a registered one-cycle pulse, 1 in the cycle after any edge at which q took a different value.

Function
REQ-017 Latency SHALL be one clock: an operation sampled at edge N is visible on q immediately after edge N.
REQ-018 Hold (mode 00), or e=0 with any mode: q SHALL keep its value.
REQ-019 Shift right, ROTATE=0: q SHALL become {sin_r, q[WIDTH-1:1]}.
REQ-020 Shift left, ROTATE=0: q SHALL become {q[WIDTH-2:0], sin_l}.
REQ-021 Shift right, ROTATE=1: q SHALL become {q[0], q[WIDTH-1:1]}.
REQ-022 Shift left, ROTATE=1: q SHALL become {q[WIDTH-2:0], q[WIDTH-1]}.
REQ-023 Parallel load (mode 11): q SHALL become d.
REQ-024 The block SHALL contain only edge-triggered storage; no level-sensitive latch SHALL be inferred.
REQ-025 changed SHALL be 0 when the operation leaves q unchanged (e.g. loading the same value, rotating all-ones, holding).
REQ-026 Inputs changing between edges SHALL have no effect on q.

Reset
REQ-027 reset=1 at a rising edge SHALL set q=RESET_VALUE and changed=0, overriding e and mode.
REQ-028 Reset asserted mid-sequence SHALL discard any operation sampled at that edge; normal operation SHALL resume at the first edge with reset=0.
REQ-029 Reset SHALL NOT act between clock edges.

Verification (WIDTH=8, RESET_VALUE=0 unless noted)
REQ-030 reset=1 for one edge with e=1, mode=11, d=8'hFF -> q=8'h00, zero=1, changed=0.
REQ-031 e=1, mode=11, d=8'hA5 -> q=8'hA5, changed=1 next cycle; repeat the load with d=8'hA5 -> changed=0.
REQ-032 q=8'hA5, mode=01, sin_r=1, ROTATE=0 -> q=8'hD2, sout_r=0; then mode=10, sin_l=0 -> q=8'hA4.
REQ-033 ROTATE=1, q=8'h81, mode=10 -> q=8'h03; mode=01 twice from 8'h81 -> 8'hC0 then 8'h60.
REQ-034 q=8'h3C, e=0, cycle mode through 01, 10, 11 with d=8'h00 -> q stays 8'h3C, changed=0 throughout.
REQ-035 RESET_VALUE=8'h5A, reset asserted in the same cycle as mode=11, d=8'h11 -> q=8'h5A; d toggled between edges with reset=0, e=0 -> q unchanged.

Source files
------------

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - parameterised universal shift register with load, shift/rotate and change flag
module universal_shift_register #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    parameter bit                 ROTATE      = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             zero,
    output logic             changed
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] q_next;
    logic             fill_msb;
    logic             fill_lsb;

    // In rotate mode the bit falling off one end re-enters at the other.
    assign fill_msb = ROTATE ? q[0]       : sin_r;
    assign fill_lsb = ROTATE ? q[WIDTH-1] : sin_l;

    always_comb begin
        q_next = q;
        if (e) begin
            case (mode)
                MODE_HOLD:  q_next = q;
                MODE_RIGHT: q_next = {fill_msb, q[WIDTH-1:1]};
                MODE_LEFT:  q_next = {q[WIDTH-2:0], fill_lsb};
                MODE_LOAD:  q_next = d;
                default:    q_next = q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= RESET_VALUE;
            changed <= 1'b0;
        end else begin
            q       <= q_next;
            changed <= (q_next != q);
        end
    end

    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];
    assign zero   = (q == '0);

endmodule

// File: tb/tb_universal_shift_register.sv
// tb/tb_universal_shift_register.sv - self-checking bench for universal_shift_register (three parameterisations)
module tb_universal_shift_register;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       e = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] d = 8'h00;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;

    logic [7:0] q_o [3];
    logic       sr_o [3];
    logic       sl_o [3];
    logic       z_o [3];
    logic       ch_o [3];

    // inst 0: default, inst 1: rotating, inst 2: RESET_VALUE=8'h5A
    logic [7:0] mq [3];
    logic       mc [3];
    bit         rot_cfg [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] rv_cfg [3]  = '{8'h00, 8'h00, 8'h5A};

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    universal_shift_register u_plain (
        .clk(clk), .reset(reset), .e(e), .mode(mode), .d(d), .sin_r(sin_r), .sin_l(sin_l),
        .q(q_o[0]), .sout_r(sr_o[0]), .sout_l(sl_o[0]), .zero(z_o[0]), .changed(ch_o[0])
    );

    universal_shift_register #(.WIDTH(8), .RESET_VALUE(8'h00), .ROTATE(1'b1)) u_rot (
        .clk(clk), .reset(reset), .e(e), .mode(mode), .d(d), .sin_r(sin_r), .sin_l(sin_l),
        .q(q_o[1]), .sout_r(sr_o[1]), .sout_l(sl_o[1]), .zero(z_o[1]), .changed(ch_o[1])
    );

    universal_shift_register #(.WIDTH(8), .RESET_VALUE(8'h5A), .ROTATE(1'b0)) u_rv (
        .clk(clk), .reset(reset), .e(e), .mode(mode), .d(d), .sin_r(sin_r), .sin_l(sin_l),
        .q(q_o[2]), .sout_r(sr_o[2]), .sout_l(sl_o[2]), .zero(z_o[2]), .changed(ch_o[2])
    );

    function automatic logic [7:0] model_next(input logic [7:0] cur, input bit rot, input logic [7:0] rv);
        int v;
        int in_bit;
        v = int'(cur);
        if (reset) return rv;
        if (!e) return cur;
        case (mode)
            2'b01: begin
                in_bit = rot ? (v % 2) : int'(sin_r);
                return 8'((v / 2) + in_bit * 128);
            end
            2'b10: begin
                in_bit = rot ? (v / 128) : int'(sin_l);
                return 8'(((v * 2) % 256) + in_bit);
            end
            2'b11:   return d;
            default: return cur;
        endcase
    endfunction

    task automatic step();
        logic [7:0] nx;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            nx    = model_next(mq[i], rot_cfg[i], rv_cfg[i]);
            mc[i] = reset ? 1'b0 : (nx != mq[i]);
            mq[i] = nx;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; e = 1'b1; mode = 2'b11; d = 8'hFF;
        step();
        total++; if (q_o[0] !== 8'h00) $display("FAIL reset_q q=%h expected 00", q_o[0]); else passed++;
        total++; if (z_o[0] !== 1'b1) $display("FAIL reset_zero zero=%b expected 1", z_o[0]); else passed++;
        total++; if (ch_o[0] !== 1'b0) $display("FAIL reset_changed changed=%b expected 0", ch_o[0]); else passed++;
        total++; if (q_o[2] !== 8'h5A) $display("FAIL reset_rv_q q=%h expected 5a", q_o[2]); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_load();
        e = 1'b1; mode = 2'b11; d = 8'hA5;
        step();
        total++; if (q_o[0] !== 8'hA5) $display("FAIL load_q q=%h expected a5", q_o[0]); else passed++;
        total++; if (ch_o[0] !== 1'b1) $display("FAIL load_changed changed=%b expected 1", ch_o[0]); else passed++;
        step();
        total++; if (q_o[0] !== 8'hA5) $display("FAIL reload_q q=%h expected a5", q_o[0]); else passed++;
        total++; if (ch_o[0] !== 1'b0) $display("FAIL reload_changed changed=%b expected 0", ch_o[0]); else passed++;
    endtask

    task automatic test_shift();
        mode = 2'b01; sin_r = 1'b1;
        step();
        total++; if (q_o[0] !== 8'hD2) $display("FAIL shr_q q=%h expected d2", q_o[0]); else passed++;
        total++; if (sr_o[0] !== 1'b0) $display("FAIL shr_sout_r sout_r=%b expected 0", sr_o[0]); else passed++;
        total++; if (sl_o[0] !== 1'b1) $display("FAIL shr_sout_l sout_l=%b expected 1", sl_o[0]); else passed++;
        total++; if (q_o[1] !== mq[1]) $display("FAIL shr_rot_q q=%h expected %h", q_o[1], mq[1]); else passed++;
        mode = 2'b10; sin_l = 1'b0;
        step();
        total++; if (q_o[0] !== 8'hA4) $display("FAIL shl_q q=%h expected a4", q_o[0]); else passed++;
        total++; if (q_o[1] !== mq[1]) $display("FAIL shl_rot_q q=%h expected %h", q_o[1], mq[1]); else passed++;
    endtask

    task automatic test_rotate();
        e = 1'b1; mode = 2'b11; d = 8'h81; sin_r = 1'b0; sin_l = 1'b0;
        step();
        mode = 2'b10;
        step();
        total++; if (q_o[1] !== 8'h03) $display("FAIL rotl_q q=%h expected 03", q_o[1]); else passed++;
        total++; if (q_o[0] !== 8'h02) $display("FAIL shl_serial_q q=%h expected 02", q_o[0]); else passed++;
        mode = 2'b11;
        step();
        mode = 2'b01;
        step();
        total++; if (q_o[1] !== 8'hC0) $display("FAIL rotr1_q q=%h expected c0", q_o[1]); else passed++;
        step();
        total++; if (q_o[1] !== 8'h60) $display("FAIL rotr2_q q=%h expected 60", q_o[1]); else passed++;
        mode = 2'b11; d = 8'hFF;
        step();
        mode = 2'b10;
        step();
        total++; if (ch_o[1] !== 1'b0) $display("FAIL rot_ones_changed changed=%b expected 0", ch_o[1]); else passed++;
        total++; if (q_o[1] !== 8'hFF) $display("FAIL rot_ones_q q=%h expected ff", q_o[1]); else passed++;
    endtask

    task automatic test_hold();
        e = 1'b1; mode = 2'b11; d = 8'h3C;
        step();
        e = 1'b0; d = 8'h00;
        for (int m = 1; m <= 3; m++) begin
            mode = 2'(m);
            step();
            total++; if (q_o[0] !== 8'h3C) $display("FAIL hold_q mode=%0d q=%h expected 3c", m, q_o[0]); else passed++;
            total++; if (ch_o[0] !== 1'b0) $display("FAIL hold_changed mode=%0d changed=%b expected 0", m, ch_o[0]); else passed++;
        end
        e = 1'b1; mode = 2'b00;
        step();
        total++; if (q_o[0] !== 8'h3C) $display("FAIL hold_mode0_q q=%h expected 3c", q_o[0]); else passed++;
    endtask

    task automatic test_reset_value();
        reset = 1'b1; e = 1'b1; mode = 2'b11; d = 8'h11;
        step();
        total++; if (q_o[2] !== 8'h5A) $display("FAIL rv_reset_q q=%h expected 5a", q_o[2]); else passed++;
        total++; if (ch_o[2] !== 1'b0) $display("FAIL rv_reset_changed changed=%b expected 0", ch_o[2]); else passed++;
        reset = 1'b0; e = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d = 8'($urandom);
            #2 d = ~d;
            #1 mode = 2'($urandom);
            step();
            total++; if (q_o[2] !== 8'h5A) $display("FAIL rv_hold_q q=%h expected 5a", q_o[2]); else passed++;
        end
        e = 1'b1; mode = 2'b11; d = 8'h11;
        step();
        total++; if (q_o[2] !== 8'h11) $display("FAIL rv_resume_q q=%h expected 11", q_o[2]); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 15) == 0);
            e     = ($urandom_range(0, 7) != 0);
            mode  = 2'($urandom);
            d     = ($urandom_range(0, 3) == 0) ? q_o[0] : 8'($urandom);
            sin_r = 1'($urandom);
            sin_l = 1'($urandom);
            step();
            for (int i = 0; i < 3; i++) begin
                total++;
                if (q_o[i] !== mq[i] || ch_o[i] !== mc[i] || z_o[i] !== (mq[i] == 8'h00) ||
                    sr_o[i] !== mq[i][0] || sl_o[i] !== mq[i][7])
                    $display("FAIL rand inst%0d cyc%0d q=%h ch=%b z=%b sr=%b sl=%b expected q=%h ch=%b",
                             i, n, q_o[i], ch_o[i], z_o[i], sr_o[i], sl_o[i], mq[i], mc[i]);
                else passed++;
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            mq[i] = 8'h00;
            mc[i] = 1'b0;
        end
        #2;
        test_reset();
        test_load();
        test_shift();
        test_rotate();
        test_hold();
        test_reset_value();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
